// File: rtl/ahb_gpio_pkg.sv
// ahb_gpio_pkg: shared AHB encodings, register map and FSM states for the GPIO block.
package ahb_gpio_pkg;
  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [2:0] REG_DATA_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR        = 3'd1;
  localparam logic [2:0] REG_DATA_IN    = 3'd2;
  localparam logic [2:0] REG_INT_EN     = 3'd3;
  localparam logic [2:0] REG_INT_POL    = 3'd4;
  localparam logic [2:0] REG_INT_STATUS = 3'd5;
  localparam logic [2:0] SIZE_WORD      = 3'b010;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_gpio_port.sv
// ahb_gpio_port: one GPIO port with data/direction registers, input synchroniser and edge interrupts.
module ahb_gpio_port import ahb_gpio_pkg::*; #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [2:0]   rsel,
  input  logic [W-1:0] wdata,
  input  logic [W-1:0] pin,
  output logic [W-1:0] rdata,
  output logic [W-1:0] dout,
  output logic [W-1:0] dir,
  output logic         pend
);
  logic [W-1:0] dout_q, dout_d, dir_q, dir_d, en_q, en_d, pol_q, pol_d, sts_q, sts_d;
  logic [W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  always_comb begin
    dout_d  = we && rsel == REG_DATA_OUT ? wdata : dout_q;
    dir_d   = we && rsel == REG_DIR      ? wdata : dir_q;
    en_d    = we && rsel == REG_INT_EN   ? wdata : en_q;
    pol_d   = we && rsel == REG_INT_POL  ? wdata : pol_q;
    // a fresh edge is ORed in after the clear so it is never lost to a W1C
    sts_d   = (sts_q & ~(we && rsel == REG_INT_STATUS ? wdata : '0))
            | (pol_q & sync2_q & ~prev_q) | (~pol_q & ~sync2_q & prev_q);
    sync1_d = pin;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      dir_q   <= '0;
      en_q    <= '0;
      pol_q   <= '0;
      sts_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      pol_q   <= pol_d;
      sts_q   <= sts_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end
  assign rdata = rsel == REG_DATA_OUT   ? dout_q  :
                 rsel == REG_DIR        ? dir_q   :
                 rsel == REG_DATA_IN    ? sync2_q :
                 rsel == REG_INT_EN     ? en_q    :
                 rsel == REG_INT_POL    ? pol_q   :
                 rsel == REG_INT_STATUS ? sts_q   : '0;
  assign dout = dout_q;
  assign dir  = dir_q;
  assign pend = |(sts_q & en_q);
endmodule

// File: rtl/ahb_gpio_multi.sv
// ahb_gpio_multi: AHB slave exposing NUM_PORTS GPIO ports with wait states, error responses and a shared irq.
module ahb_gpio_multi import ahb_gpio_pkg::*; #(
  parameter int NUM_PORTS   = 2,
  parameter int PORT_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sel,
  input  logic [31:0]                      addr,
  input  logic [1:0]                       trans,
  input  logic                             write,
  input  logic [2:0]                       size,
  input  logic [31:0]                      wdata,
  input  logic                             ready,
  output logic                             readyout,
  output logic                             resp,
  output logic [31:0]                      rdata,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_oe,
  output logic                             irq
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] port_q, port_d, reg_q, reg_d;
  logic write_q, write_d, irq_q, irq_d;
  logic accept, bad, commit;
  logic [NUM_PORTS-1:0] pend;
  logic [PORT_WIDTH-1:0] prd [NUM_PORTS];
  logic [PORT_WIDTH-1:0] sel_rd;
  logic unused_bits;
  assign unused_bits = ^{addr[31:8], addr[1:0], wdata, trans[0]};
  assign accept = sel && ready && (trans == TRANS_NONSEQ || trans == TRANS_SEQ)
                && (state_q == ST_IDLE || state_q == ST_ACCESS || state_q == ST_ERR2);
  assign bad = int'(addr[7:5]) >= NUM_PORTS || addr[4:2] > REG_INT_STATUS || size != SIZE_WORD;
  assign commit = state_q == ST_ACCESS && write_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    reg_d   = reg_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d   = cnt_q <= 2'd1 ? 2'd0 : cnt_q - 2'd1;
        state_d = cnt_q <= 2'd1 ? ST_ACCESS : ST_WAIT;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      port_d  = addr[7:5];
      reg_d   = addr[4:2];
      write_d = write;
      state_d = bad ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_ACCESS;
      cnt_d   = bad ? 2'd0 : 2'(WAIT_STATES);
    end
    irq_d = |pend;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      port_q  <= '0;
      reg_q   <= '0;
      write_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      reg_q   <= reg_d;
      write_q <= write_d;
      irq_q   <= irq_d;
    end
  end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ahb_gpio_port #(.W(PORT_WIDTH)) u_port (
      .clk   (clk),
      .reset (reset),
      .we    (commit && port_q == 3'(p)),
      .rsel  (reg_q),
      .wdata (wdata[PORT_WIDTH-1:0]),
      .pin   (gpio_in[p*PORT_WIDTH +: PORT_WIDTH]),
      .rdata (prd[p]),
      .dout  (gpio_out[p*PORT_WIDTH +: PORT_WIDTH]),
      .dir   (gpio_oe[p*PORT_WIDTH +: PORT_WIDTH]),
      .pend  (pend[p])
    );
  end
  always_comb begin
    sel_rd = '0;
    for (int i = 0; i < NUM_PORTS; i++) sel_rd = port_q == 3'(i) ? prd[i] : sel_rd;
  end
  assign readyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign resp     = state_q == ST_ERR1 || state_q == ST_ERR2;
  assign rdata    = state_q == ST_ACCESS && !write_q ? 32'(sel_rd) : '0;
  assign irq      = irq_q;
endmodule

// File: tb/tb_ahb_gpio_multi.sv
// tb_ahb_gpio_multi: directed checks of a zero-wait and a two-wait-state GPIO slave.
module tb_ahb_gpio_multi;
  logic clk = 0, reset = 1;
  logic sel0 = 0, sel2 = 0, write = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [1:0] trans = 0;
  logic [2:0] size = 3'b010;
  logic [31:0] gpio_in = 0;
  logic readyout0, resp0, irq0, readyout2, resp2, irq2;
  logic [31:0] rdata0, rdata2, gpio_out0, gpio_oe0, gpio_out2, gpio_oe2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ahb_gpio_multi #(.NUM_PORTS(2), .PORT_WIDTH(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .sel(sel0), .addr(addr), .trans(trans), .write(write),
    .size(size), .wdata(wdata), .ready(readyout0), .readyout(readyout0), .resp(resp0),
    .rdata(rdata0), .gpio_in(gpio_in), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0), .irq(irq0));

  ahb_gpio_multi #(.NUM_PORTS(2), .PORT_WIDTH(16), .WAIT_STATES(2)) u2 (
    .clk(clk), .reset(reset), .sel(sel2), .addr(addr), .trans(trans), .write(write),
    .size(size), .wdata(wdata), .ready(readyout2), .readyout(readyout2), .resp(resp2),
    .rdata(rdata2), .gpio_in(gpio_in), .gpio_out(gpio_out2), .gpio_oe(gpio_oe2), .irq(irq2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit slow, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output int lows, output logic r_lo,
                      output logic r_hi, output logic [31:0] rd);
    @(negedge clk);
    sel0 = !slow; sel2 = slow; addr = a; write = wr; size = sz; trans = 2'b10;
    @(posedge clk);
    @(negedge clk);
    sel0 = 0; sel2 = 0; trans = 2'b00; wdata = wd; lows = 0; r_lo = 0;
    while ((slow ? readyout2 : readyout0) !== 1'b1 && lows < 20) begin
      r_lo = slow ? resp2 : resp0;
      lows++;
      @(negedge clk);
    end
    r_hi = slow ? resp2 : resp0;
    rd = slow ? rdata2 : rdata0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lows;
    logic r_lo, r_hi;
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readyout", {31'd0, readyout0}, 32'd1);
    check("rst_resp", {31'd0, resp0}, 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_irq", {31'd0, irq0}, 32'd0);
    check("rst_gpio_out", gpio_out0, 32'd0);
    check("rst_gpio_oe", gpio_oe0, 32'd0);
    reset = 0;

    xfer(0, 1, 32'h00, 3'b010, 32'h0000A5A5, lows, r_lo, r_hi, rd);
    check("ws0_wr_lows", lows, 0);
    check("ws0_wr_resp", {31'd0, r_hi}, 32'd0);
    check("ws0_gpio_out", {16'd0, gpio_out0[15:0]}, 32'hA5A5);
    xfer(0, 0, 32'h00, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("ws0_rd_lows", lows, 0);
    check("ws0_rd_data", rd, 32'h0000A5A5);
    check("idle_rdata", rdata0, 32'd0);

    xfer(0, 1, 32'hFFFF_FF24, 3'b010, 32'hFFFF00F0, lows, r_lo, r_hi, rd);
    check("p1_gpio_oe", gpio_oe0, 32'h00F0_0000);
    xfer(0, 0, 32'h24, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("p1_dir_rd", rd, 32'h0000_00F0);

    xfer(1, 0, 32'h04, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("ws2_rd_lows", lows, 2);
    check("ws2_rd_lowresp", {31'd0, r_lo}, 32'd0);
    check("ws2_rd_resp", {31'd0, r_hi}, 32'd0);
    check("ws2_rd_data", rd, 32'd0);
    xfer(1, 1, 32'h00, 3'b010, 32'h1234, lows, r_lo, r_hi, rd);
    check("ws2_wr_lows", lows, 2);
    check("ws2_gpio_out", gpio_out2, 32'h0000_1234);
    xfer(1, 0, 32'h00, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("ws2_rd2_data", rd, 32'h1234);

    xfer(0, 0, 32'h40, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("badport_lows", lows, 1);
    check("badport_resp1", {31'd0, r_lo}, 32'd1);
    check("badport_resp2", {31'd0, r_hi}, 32'd1);
    check("badport_rdata", rd, 32'd0);
    xfer(0, 1, 32'h18, 3'b010, 32'hFFFF, lows, r_lo, r_hi, rd);
    check("badreg_resp", {31'd0, r_hi}, 32'd1);
    xfer(0, 1, 32'h00, 3'b000, 32'hFFFF, lows, r_lo, r_hi, rd);
    check("byte_lows", lows, 1);
    check("byte_resp", {31'd0, r_hi}, 32'd1);
    check("byte_gpio_out", gpio_out0, 32'h0000A5A5);
    xfer(0, 0, 32'h00, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("byte_dout_rd", rd, 32'h0000A5A5);
    check("byte_after_resp", {31'd0, r_hi}, 32'd0);

    xfer(0, 1, 32'h2C, 3'b010, 32'h1, lows, r_lo, r_hi, rd);
    xfer(0, 1, 32'h30, 3'b010, 32'h1, lows, r_lo, r_hi, rd);
    xfer(0, 0, 32'h2C, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("int_en_rd", rd, 32'h1);
    @(negedge clk);
    gpio_in[16] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("irq_not_yet", {31'd0, irq0}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("irq_set", {31'd0, irq0}, 32'd1);
    check("irq2_disabled", {31'd0, irq2}, 32'd0);
    xfer(0, 0, 32'h34, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("int_status_rd", rd, 32'h1);
    xfer(0, 0, 32'h28, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("data_in_rd", rd, 32'h1);
    xfer(0, 1, 32'h28, 3'b010, 32'hFFFF, lows, r_lo, r_hi, rd);
    check("data_in_wr_resp", {31'd0, r_hi}, 32'd0);
    xfer(0, 0, 32'h28, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("data_in_ro", rd, 32'h1);
    check("irq_held", {31'd0, irq0}, 32'd1);
    xfer(0, 1, 32'h34, 3'b010, 32'h1, lows, r_lo, r_hi, rd);
    @(posedge clk);
    @(negedge clk);
    check("irq_cleared", {31'd0, irq0}, 32'd0);
    xfer(0, 0, 32'h34, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("int_status_clr", rd, 32'd0);
    xfer(1, 0, 32'h34, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("ws2_no_rise", rd, 32'd0);

    @(negedge clk);
    gpio_in[16] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("fall_no_irq0", {31'd0, irq0}, 32'd0);
    check("fall_no_irq2", {31'd0, irq2}, 32'd0);
    xfer(1, 0, 32'h34, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("ws2_fall_status", rd, 32'h1);
    xfer(0, 0, 32'h34, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("ws0_fall_status", rd, 32'd0);

    @(negedge clk);
    sel2 = 1; addr = 32'h20; write = 1; size = 3'b010; trans = 2'b10;
    @(posedge clk);
    @(negedge clk);
    sel2 = 0; trans = 2'b00; wdata = 32'hBEEF;
    check("abort_in_wait", {31'd0, readyout2}, 32'd0);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("abort_readyout", {31'd0, readyout2}, 32'd1);
    check("abort_resp", {31'd0, resp2}, 32'd0);
    reset = 0;
    repeat (3) @(posedge clk);
    check("abort_gpio_out", gpio_out2, 32'd0);
    xfer(1, 0, 32'h20, 3'b010, 0, lows, r_lo, r_hi, rd);
    check("abort_reg_zero", rd, 32'd0);
    check("abort_rd_lows", lows, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
